// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in the EX stage.
// Latency: 1 capture cycle + ITER shift cycles, then done_o (special divides: 1 cycle, then done_o).
// Backpressure: stall_i is honoured in IDLE (no capture) and DONE (result held); BUSY ignores it.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-low reset
//   ALUOp_i/funct3_i/funct7_i  decode fields from ID/EX
//   RS1data_i, RS2data_i     forwarded operands
//   stall_i                  memory stall, pipeline frozen this cycle
//   stall_o                  multi-cycle stall request into the hazard network
//   result_o, done_o         registered result and its one-shot valid
module ex_muldiv #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [1:0]      ALUOp_i,
   input  logic [2:0]      funct3_i,
   input  logic [6:0]      funct7_i,
   input  logic [XLEN-1:0] RS1data_i,
   input  logic [XLEN-1:0] RS2data_i,
   input  logic            stall_i,
   output logic            stall_o,
   output logic [XLEN-1:0] result_o,
   output logic            done_o
);

   localparam int W2 = 2 * XLEN;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t state_q, state_d;

   logic [2:0]      op_q;
   logic            neg_q;      // negate product / quotient
   logic            neg_r_q;    // negate remainder (sign of dividend)
   logic [XLEN-1:0] mcand_q;    // multiplicand or divisor magnitude
   logic [W2-1:0]   acc_q;      // product accumulator or remainder:quotient
   logic [31:0]     cnt_q;

   // Decode of the instruction currently sitting in ID/EX
   logic is_m;
   assign is_m = (ALUOp_i == 2'b10) && (funct7_i == 7'b0000001);

   logic            is_div, sgn1, sgn2, s1, s2, div_zero, div_ovf, special;
   logic [XLEN-1:0] mag1, mag2, special_res;

   always_comb begin
      is_div   = funct3_i[2];
      // rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM.
      // MUL is treated as signed: the low half of the product is unaffected.
      sgn1     = ~funct3_i[0] | (funct3_i == 3'b001);
      sgn2     = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b110);
      s1       = sgn1 & RS1data_i[XLEN-1];
      s2       = sgn2 & RS2data_i[XLEN-1];
      mag1     = s1 ? (~RS1data_i + 1'b1) : RS1data_i;
      mag2     = s2 ? (~RS2data_i + 1'b1) : RS2data_i;
      div_zero = is_div && (RS2data_i == '0);
      div_ovf  = is_div && ~funct3_i[0] && (RS1data_i == INT_MIN) && (RS2data_i == '1);
      special  = div_zero | div_ovf;
      special_res = '0;
      if (div_zero)
         special_res = funct3_i[1] ? RS1data_i : '1;
      else if (div_ovf)
         special_res = funct3_i[1] ? '0 : INT_MIN;
   end

   // One iteration of either algorithm, plus the final sign-corrected result
   logic [XLEN:0]   mul_sum, div_trial;
   logic [W2-1:0]   mul_nxt, div_nxt, step_nxt, prod_fix;
   logic [XLEN-1:0] q_fix, r_fix, final_res;
   logic            last;

   always_comb begin
      // Shift-add: conditionally add multiplicand into the high half, shift right.
      mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
      // Restoring: trial-subtract the divisor from the shifted remainder.
      // A negative trial implies the shifted remainder fits in XLEN bits.
      div_trial = acc_q[W2-1:XLEN-1] - {1'b0, mcand_q};
      div_nxt   = div_trial[XLEN] ? {acc_q[W2-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      step_nxt  = op_q[2] ? div_nxt : mul_nxt;

      prod_fix  = neg_q   ? (~step_nxt + 1'b1) : step_nxt;
      q_fix     = neg_q   ? (~step_nxt[XLEN-1:0] + 1'b1) : step_nxt[XLEN-1:0];
      r_fix     = neg_r_q ? (~step_nxt[W2-1:XLEN] + 1'b1) : step_nxt[W2-1:XLEN];

      case (op_q)
         3'b000:                 final_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_fix[W2-1:XLEN];
         3'b100, 3'b101:         final_res = q_fix;
         default:                final_res = r_fix;
      endcase

      last = (cnt_q == 32'(ITER - 1));
   end

   // FSM
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (is_m && !stall_i) state_d = special ? S_DONE : S_BUSY;
         S_BUSY: if (last)             state_d = S_DONE;
         S_DONE: if (!stall_i)         state_d = S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         op_q     <= '0;
         neg_q    <= 1'b0;
         neg_r_q  <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_o <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (is_m && !stall_i) begin
                  op_q    <= funct3_i;
                  neg_q   <= s1 ^ s2;
                  neg_r_q <= s1;
                  // Multiplication commutes, so one layout serves both:
                  // rs1 magnitude in the low half, rs2 magnitude aside.
                  acc_q   <= {{XLEN{1'b0}}, mag1};
                  mcand_q <= mag2;
                  cnt_q   <= '0;
                  if (special) result_o <= special_res;
               end
            end
            S_BUSY: begin
               acc_q <= step_nxt;
               cnt_q <= cnt_q + 32'd1;
               if (last) result_o <= final_res;
            end
            default: ;
         endcase
      end
   end

   // Gated with rst_i so the request drops immediately on reset even while
   // an M instruction is still presented.
   assign stall_o = rst_i & is_m & (state_q != S_DONE);
   assign done_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed-vector scoreboard bench for ex_muldiv.
// Latency: stimulus holds each instruction until the DONE cycle retires it.
// Backpressure: stall_i is driven during DONE to exercise result hold.
module tb_ex_muldiv;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  ALUOp_i;
   logic [2:0]  funct3_i;
   logic [6:0]  funct7_i;
   logic [31:0] RS1data_i, RS2data_i;
   logic        stall_i;
   logic        stall_o;
   logic [31:0] result_o;
   logic        done_o;

   ex_muldiv #(.XLEN(32), .ITER(32)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .ALUOp_i   (ALUOp_i),
      .funct3_i  (funct3_i),
      .funct7_i  (funct7_i),
      .RS1data_i (RS1data_i),
      .RS2data_i (RS2data_i),
      .stall_i   (stall_i),
      .stall_o   (stall_o),
      .result_o  (result_o),
      .done_o    (done_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: compares each new completion against the scoreboard and
   // checks the result stays put while DONE is held.
   logic        done_prev = 1'b0;
   logic [31:0] held = '0;
   always @(negedge clk_i) begin
      if (done_o && !done_prev) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got result %h with empty scoreboard", result_o);
         end else begin
            chk("result", result_o, exp_q.pop_front());
         end
         held = result_o;
      end else if (done_o && done_prev) begin
         chk("held_result", result_o, held);
      end
      done_prev = done_o;
   end

   // Present an M instruction, count stall cycles until done, optionally hold
   // stall_i in DONE, then let the pipeline advance.
   task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_stall, input int hold);
      int  n    = 0;
      int  cyc  = 0;
      bit  seen = 1'b0;
      ALUOp_i   = 2'b10;
      funct7_i  = 7'b0000001;
      funct3_i  = f3;
      RS1data_i = a;
      RS2data_i = b;
      exp_q.push_back(exp);
      while (!seen && cyc < 200) begin
         @(negedge clk_i);
         cyc++;
         if (stall_o) n++;
         if (done_o) seen = 1'b1;
         else begin
            @(posedge clk_i);
            #1;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no done_o in %0d cycles want done_o", nm, cyc);
      end else begin
         chk({nm, "_stall_cycles"}, n, exp_stall);
         chk({nm, "_stall_in_done"}, {31'd0, stall_o}, 32'd0);
         if (hold > 0) begin
            stall_i = 1'b1;
            repeat (hold) begin
               @(posedge clk_i);
               @(negedge clk_i);
               chk({nm, "_done_held"}, {31'd0, done_o}, 32'd1);
               chk({nm, "_stall_held"}, {31'd0, stall_o}, 32'd0);
            end
            stall_i = 1'b0;
         end
      end
      @(posedge clk_i);
      #1;
      ALUOp_i  = 2'b00;
      funct7_i = 7'b0;
   endtask

   typedef struct {
      string       nm;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          st;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{"mul",      3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      vecs[1]  = '{"mulh",     3'b001, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 33};
      vecs[2]  = '{"mulhu",    3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      vecs[3]  = '{"mulhsu",   3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33};
      vecs[4]  = '{"div",      3'b100, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFD, 33};
      vecs[5]  = '{"rem",      3'b110, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFE, 33};
      vecs[6]  = '{"divu",     3'b101, 32'd100,        32'd7,        32'd14,       33};
      vecs[7]  = '{"remu",     3'b111, 32'd100,        32'd7,        32'd2,        33};
      vecs[8]  = '{"div_by0",  3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
      vecs[9]  = '{"rem_by0",  3'b110, 32'd5,          32'd0,        32'd5,        1};
      vecs[10] = '{"div_ovf",  3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};

      // Reset with an M instruction already presented
      rst_i     = 1'b0;
      stall_i   = 1'b0;
      ALUOp_i   = 2'b10;
      funct7_i  = 7'b0000001;
      funct3_i  = 3'b000;
      RS1data_i = 32'd3;
      RS2data_i = 32'd4;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_result", result_o, 32'd0);
      ALUOp_i  = 2'b00;
      funct7_i = 7'b0;
      rst_i    = 1'b1;

      // Non-M R-type and a flushed bubble must not stall
      ALUOp_i  = 2'b10;
      funct7_i = 7'b0000000;
      repeat (3) begin
         @(negedge clk_i);
         chk("nonm_stall", {31'd0, stall_o}, 32'd0);
         chk("nonm_done", {31'd0, done_o}, 32'd0);
      end
      ALUOp_i  = 2'b00;
      funct7_i = 7'b0000001;
      @(negedge clk_i);
      chk("bubble_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk_i);
      #1;

      // Directed vectors, issued back to back
      for (int i = 0; i < 11; i++)
         issue(vecs[i].nm, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].st, 0);

      // Hold DONE with stall_i for 3 cycles: 0xFFFFFFFF*2 = 0x1_FFFFFFFE
      issue("mulhu_hold", 3'b011, 32'hFFFFFFFF, 32'd2, 32'd1, 33, 3);

      // Two consecutive MULs
      issue("mul_a", 3'b000, 32'd12345, 32'd1000, 32'h00BC5EA8, 33, 0);
      issue("mul_b", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 33, 0);

      // Reset while BUSY with counter at 15
      ALUOp_i   = 2'b10;
      funct7_i  = 7'b0000001;
      funct3_i  = 3'b101;
      RS1data_i = 32'd1000;
      RS2data_i = 32'd7;
      repeat (16) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
      chk("midrst_stall", {31'd0, stall_o}, 32'd0);
      chk("midrst_done", {31'd0, done_o}, 32'd0);
      chk("midrst_result", result_o, 32'd0);
      ALUOp_i  = 2'b00;
      funct7_i = 7'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("postrst_done", {31'd0, done_o}, 32'd0);
      @(posedge clk_i);
      #1;
      issue("divu_after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 33, 0);

      repeat (3) @(posedge clk_i);
      #1;
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
